// File: rtl/dot_matrix_mover.sv
// Moves one lit dot around a 6x6 LED matrix from four async push-buttons, wrapping at edges.
// Latency: button first sampled high at edge k moves row/col at edge k+3.
// No backpressure: presses during the post-accept lockout are dropped, never queued.
module dot_matrix_mover #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int LOCKOUT_MS = 10,
    parameter int START_ROW  = 0,
    parameter int START_COL  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    output logic [5:0] row,
    output logic [5:0] col
);

`ifdef SIMULATION
    localparam int LOCK_MS_EFF = 1;
`else
    localparam int LOCK_MS_EFF = LOCKOUT_MS;
`endif
    localparam int LOCK_CYC = (CLK_HZ / 1000) * LOCK_MS_EFF;
    localparam int LOCK_MAX = (LOCK_CYC > 1) ? (LOCK_CYC - 1) : 1;
    localparam int LOCK_W   = $clog2(LOCK_MAX + 1);

    localparam logic [2:0] START_R = 3'(START_ROW);
    localparam logic [2:0] START_C = 3'(START_COL);

    // Bit order gives the acceptance priority: up > down > left > right.
    localparam int B_UP = 3;
    localparam int B_DN = 2;
    localparam int B_LT = 1;
    localparam int B_RT = 0;

    function automatic logic [5:0] onehot6(input logic [2:0] idx);
        logic [5:0] v;
        v = 6'b000001;
        if (idx <= 3'd5) begin
            v = 6'b000001 << idx;
        end
        return v;
    endfunction

    function automatic logic [2:0] step_dec(input logic [2:0] v);
        logic [2:0] r;
        if (v > 3'd5)       r = 3'd0;
        else if (v == 3'd0) r = 3'd5;
        else                r = v - 3'd1;
        return r;
    endfunction

    function automatic logic [2:0] step_inc(input logic [2:0] v);
        logic [2:0] r;
        if (v >= 3'd5) r = 3'd0;
        else           r = v + 3'd1;
        return r;
    endfunction

    logic [3:0]        btn_raw;
    logic [3:0]        btn_meta_q, btn_meta_d;
    logic [3:0]        btn_sync_q, btn_sync_d;
    logic [3:0]        btn_prev_q, btn_prev_d;
    logic [2:0]        armed_q, armed_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [2:0]        pos_row_q, pos_row_d;
    logic [2:0]        pos_col_q, pos_col_d;
    logic [5:0]        row_q, row_d;
    logic [5:0]        col_q, col_d;
    logic [3:0]        btn_rise;
    logic              accept;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    always_comb begin
        btn_meta_d = btn_raw;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
        armed_d    = {armed_q[1:0], 1'b1};

        // btn_prev_q still holds its reset value until three edges after reset, so a button held
        // through reset would look like a fresh edge; suppress edges until it holds a real sample.
        btn_rise = btn_sync_q & ~btn_prev_q & {4{armed_q[2]}};
        accept   = (lock_q == '0) && (btn_rise != 4'b0000);

        lock_d = lock_q;
        if (accept) begin
            lock_d = LOCK_W'(LOCK_MAX);
        end else if (lock_q != '0) begin
            lock_d = lock_q - LOCK_W'(1);
        end

        pos_row_d = (pos_row_q > 3'd5) ? 3'd0 : pos_row_q;
        pos_col_d = (pos_col_q > 3'd5) ? 3'd0 : pos_col_q;
        if (accept) begin
            if (btn_rise[B_UP])      pos_row_d = step_dec(pos_row_q);
            else if (btn_rise[B_DN]) pos_row_d = step_inc(pos_row_q);
            else if (btn_rise[B_LT]) pos_col_d = step_dec(pos_col_q);
            else if (btn_rise[B_RT]) pos_col_d = step_inc(pos_col_q);
        end

        row_d = onehot6(pos_row_q);
        col_d = ~onehot6(pos_col_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 4'b0000;
            btn_sync_q <= 4'b0000;
            btn_prev_q <= 4'b0000;
            armed_q    <= 3'b000;
            lock_q     <= '0;
            pos_row_q  <= START_R;
            pos_col_q  <= START_C;
            row_q      <= onehot6(START_R);
            col_q      <= ~onehot6(START_C);
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
            armed_q    <= armed_d;
            lock_q     <= lock_d;
            pos_row_q  <= pos_row_d;
            pos_col_q  <= pos_col_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: tb/tb_dot_matrix_mover.sv
// Directed bench for dot_matrix_mover: each stimulus step queues the expected dot position and
// due cycle; a negedge monitor pops and checks whenever row/col change, and flags unexpected moves.
module tb_dot_matrix_mover;

    localparam logic [3:0] UP = 4'b1000;
    localparam logic [3:0] DN = 4'b0100;
    localparam logic [3:0] LT = 4'b0010;
    localparam logic [3:0] RT = 4'b0001;

    typedef struct {
        int r;
        int c;
        int due;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       btn_up, btn_left, btn_right, btn_down;
    logic [5:0] row, col;

    int   cyc;
    int   checks;
    int   errors;
    bit   mon_on;
    logic [5:0] prev_row, prev_col;
    exp_t exp_q[$];

    dot_matrix_mover #(
        .CLK_HZ    (100_000),
        .LOCKOUT_MS(1),
        .START_ROW (0),
        .START_COL (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_down (btn_down),
        .row      (row),
        .col      (col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] row_of(input int r);
        logic [5:0] v;
        v = 6'b000001;
        return v << r;
    endfunction

    function automatic logic [5:0] col_of(input int c);
        logic [5:0] v;
        v = 6'b000001;
        return ~(v << c);
    endfunction

    task automatic set_btns(input logic [3:0] m);
        {btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Drive mask for 'hold' cycles; if mv, the dot must land on (r,c) exactly 3 edges after first sample.
    task automatic step(input logic [3:0] m, input int hold, input int gap,
                        input bit mv, input int r, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        set_btns(m);
        if (mv) begin
            e.r   = r;
            e.c   = c;
            e.due = cyc + 1 + 3;
            exp_q.push_back(e);
        end
        repeat (hold) @(posedge clk);
        #1;
        set_btns(4'b0000);
        repeat (gap) @(posedge clk);
    endtask

    task automatic start_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        e.r   = 0;
        e.c   = 0;
        e.due = cyc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (!$onehot(row) || !$onehot(~col)) begin
                errors++;
                $display("FAIL onehot: row=%b col=%b at cycle %0d", row, col, cyc);
            end
            if (row !== prev_row || col !== prev_col) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_move: row=%b col=%b at cycle %0d, expected no change",
                             row, col, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (row !== row_of(e.r) || col !== col_of(e.c) || cyc != e.due) begin
                        errors++;
                        $display("FAIL move: row=%b col=%b cycle=%0d, expected row=%b col=%b cycle=%0d",
                                 row, col, cyc, row_of(e.r), col_of(e.c), e.due);
                    end
                end
            end
            prev_row = row;
            prev_col = col;
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        mon_on   = 1'b0;
        rst      = 1'b1;
        set_btns(4'b0000);
        prev_row = 6'b000001;
        prev_col = 6'b111110;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset_row", row, 6'b000001);
        check_vec("reset_col", col, 6'b111110);
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (200) @(posedge clk);
        @(negedge clk);
        check_vec("idle_row", row, 6'b000001);
        check_vec("idle_col", col, 6'b111110);

        step(UP,      1,   120, 1, 5, 0);   // row wraps 0 -> 5
        step(RT,      1,   120, 1, 5, 1);
        step(DN,      1,   120, 1, 0, 1);   // row wraps 5 -> 0
        step(DN,      1,   120, 1, 1, 1);
        step(DN,      300, 120, 1, 2, 1);   // long hold gives one move
        step(DN,      1,   20,  1, 3, 1);
        step(DN,      1,   120, 0, 0, 0);   // lands inside lockout
        step(UP | RT, 1,   120, 1, 2, 1);   // up wins, right dropped
        step(LT,      1,   120, 1, 2, 0);
        for (int i = 1; i <= 5; i++) begin
            step(RT, 1, 120, 1, 2, i);
        end
        step(RT,      1,   120, 1, 2, 0);   // col wraps 5 -> 0
        step(DN,      1,   120, 1, 3, 0);
        step(LT,      1,   120, 1, 3, 5);
        step(LT,      1,   20,  1, 3, 4);

        // Reset mid-lockout with the dot at (3,4).
        start_reset();
        @(negedge clk);
        check_vec("rst_mid_row", row, 6'b000001);
        check_vec("rst_mid_col", col, 6'b111110);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(UP,      1,   120, 1, 5, 0);

        // Button held across reset release must not move until re-pressed.
        start_reset();
        #5;
        btn_down = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        btn_down = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_vec("held_row", row, 6'b000001);
        check_vec("held_col", col, 6'b111110);
        step(DN,      1,   120, 1, 1, 0);

        repeat (20) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_moves: %0d expected moves never appeared, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
